wb_write_port_ctrl: RTL and testbench
=====================================

Name: wb_write_port_ctrl

Overview:
Writer-side controller for the pipeline's single-write-port register file. It merges single-cycle ALU results and valid/ready long-latency results (load/MUL) onto one registered write port. Long-latency results go through a small FIFO. The block also exposes pending-write lookups for hazard stalling and enforces write-after-write order between the two sources.

Parameters:
DATA_WIDTH, 32, width of write data
ADD_WIDTH, 5, register address width
FIFO_DEPTH, 4, long-latency buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
alu_valid  in  1  ALU result present this cycle
alu_rd  in  ADD_WIDTH  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
alu_stall  out  1  combinational; ALU result not taken, upstream must hold it
ld_valid  in  1  long-latency result valid
ld_ready  out  1  long-latency result accepted when ld_valid && ld_ready
ld_rd  in  ADD_WIDTH  long-latency destination
ld_data  in  DATA_WIDTH  long-latency result
pend_addr_a  in  ADD_WIDTH  hazard query address A
pend_addr_b  in  ADD_WIDTH  hazard query address B
pend_hit_a  out  1  FIFO holds a write to pend_addr_a
pend_hit_b  out  1  FIFO holds a write to pend_addr_b
wr_en  out  1  register file write enable (registered)
wr_addr  out  ADD_WIDTH  register file write address (registered)
wr_data  out  DATA_WIDTH  register file write data (registered)

Behaviour:
- Reset (async, rst=1): FIFO empty (rd/wr pointers and count = 0), wr_en=0, wr_addr=0, wr_data=0. ld_ready=0 while rst=1. In-flight FIFO entries are discarded; a reset that asserts mid-cycle drops any partial transfer.
- hit(x): 1 when x != 0 and any occupied FIFO entry has rd == x. Combinational over stored entries only, not the output register. pend_hit_a = hit(pend_addr_a); pend_hit_b = hit(pend_addr_b).
- alu_take = alu_valid && alu_rd != 0.
- alu_stall = alu_take && (count == FIFO_DEPTH || hit(alu_rd)). This covers the full-buffer case and enforces WAW ordering.
- ld_ready = !rst && (count < FIFO_DEPTH). It does not depend on the same-cycle pop.
- Push: ld_valid && ld_ready && ld_rd != 0 writes {ld_rd, ld_data} at the tail. A handshake with ld_rd == 0 is accepted and dropped.
- Issue arbitration, evaluated each cycle:
  - alu_take && !alu_stall: issue the ALU write (ALU has priority).
  - Otherwise, if count > 0: pop the head and issue it.
  - Otherwise: no write.
- On the next clk edge, wr_en/wr_addr/wr_data take the issued write (one-cycle latency). wr_en=0 when nothing is issued; wr_addr/wr_data then hold their previous values.
- alu_valid with alu_rd == 0 is a no-op and never stalls.
- Same-cycle push and pop: count unchanged; pointers wrap modulo FIFO_DEPTH.
- A push into an empty FIFO is not issued in the same cycle; earliest issue is the following cycle, so a load result reaches wr_en at least 2 cycles after its handshake.
- Progress guarantee: every stall cycle pops one FIFO entry, so alu_stall clears within FIFO_DEPTH cycles.
- Write to register 0 never appears on wr_en.

Test Plan:
- Reset then ALU only: alu_valid=1, alu_rd=5, alu_data=0x11 -> next cycle wr_en=1, wr_addr=5, wr_data=0x11; alu_stall=0 throughout.
- Load into idle block: ld_valid=1, ld_rd=7, ld_data=0xAB at cycle 0 -> pend_hit for 7 =1 in cycle 1; wr_en=1, wr_addr=7, wr_data=0xAB after edge 2; pend_hit for 7 =0 afterward.
- Fill FIFO: 4 loads (rd 1..4) pushed while ALU writes rd 9 every cycle -> ld_ready=0 at count=4. Next ALU write raises alu_stall and head rd=1 is written. ALU rd 9 is written once count < 4. Loads drain in order 1,2,3,4.
- WAW: load rd=6 buffered, then ALU rd=6 -> alu_stall=1 until the load write to 6 is issued. The ALU write to 6 follows, so the final register 6 value equals alu_data.
- Zero register: ALU rd=0 and load rd=0 -> no wr_en, count stays 0, alu_stall=0.
- Reset mid-operation: rst=1 with count=3 -> immediately wr_en=0, ld_ready=0, all pend_hit=0. After release, ld_ready=1 and no stale writes are issued.

Source files
------------

// File: rtl/wb_write_port_ctrl.sv
// Single write-port arbiter for the register file: ALU results bypass, long-latency
// results are buffered in a small FIFO that also answers pending-write hazard queries.
module wb_write_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [ADD_WIDTH-1:0]  alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_stall,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADD_WIDTH-1:0]  ld_rd,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic [ADD_WIDTH-1:0]  pend_addr_a,
    input  logic [ADD_WIDTH-1:0]  pend_addr_b,
    output logic                  pend_hit_a,
    output logic                  pend_hit_b,
    output logic                  wr_en,
    output logic [ADD_WIDTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [ADD_WIDTH-1:0]  r_fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;

    logic [FIFO_DEPTH-1:0] w_occ;
    logic [FIFO_DEPTH-1:0] w_hit_a;
    logic [FIFO_DEPTH-1:0] w_hit_b;
    logic [FIFO_DEPTH-1:0] w_hit_alu;
    logic                  w_full;
    logic                  w_alu_take;
    logic                  w_alu_issue;
    logic                  w_push;
    logic                  w_pop;

    // An entry is live when its distance from the head is below the occupancy count.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [PW-1:0] w_offset;
            assign w_offset      = PW'(gi) - r_rd_ptr;
            assign w_occ[gi]     = ({1'b0, w_offset} < r_count);
            assign w_hit_a[gi]   = w_occ[gi] && (r_fifo_rd[gi] == pend_addr_a);
            assign w_hit_b[gi]   = w_occ[gi] && (r_fifo_rd[gi] == pend_addr_b);
            assign w_hit_alu[gi] = w_occ[gi] && (r_fifo_rd[gi] == alu_rd);
        end
    endgenerate

    assign pend_hit_a  = (pend_addr_a != '0) && (|w_hit_a);
    assign pend_hit_b  = (pend_addr_b != '0) && (|w_hit_b);

    assign w_full      = (r_count == FULL_COUNT);
    assign w_alu_take  = alu_valid && (alu_rd != '0);
    // Holding the ALU behind a buffered write to the same register keeps WAW order.
    assign alu_stall   = w_alu_take && (w_full || (|w_hit_alu));
    assign ld_ready    = !rst && !w_full;
    assign w_push      = ld_valid && ld_ready && (ld_rd != '0);
    assign w_alu_issue = w_alu_take && !alu_stall;
    assign w_pop       = !w_alu_issue && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= ld_rd;
            r_fifo_data[r_wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (w_alu_issue) begin
            wr_en   <= 1'b1;
            wr_addr <= alu_rd;
            wr_data <= alu_data;
        end else if (w_pop) begin
            wr_en   <= 1'b1;
            wr_addr <= r_fifo_rd[r_rd_ptr];
            wr_data <= r_fifo_data[r_rd_ptr];
        end else begin
            wr_en   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_write_port_ctrl.sv
// Directed bench for wb_write_port_ctrl: expected writes are queued by the stimulus
// and consumed by a monitor whenever the register-file port fires.
module tb_wb_write_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  pend_addr_a;
    logic [4:0]  pend_addr_b;
    logic        pend_hit_a;
    logic        pend_hit_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int total = 0;
    int bad   = 0;

    logic [4:0]  q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] shadow [32];

    wb_write_port_ctrl #(.DATA_WIDTH(32), .ADD_WIDTH(5), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .pend_addr_a(pend_addr_a), .pend_addr_b(pend_addr_b),
        .pend_hit_a(pend_hit_a), .pend_hit_b(pend_hit_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        q_addr.push_back(a);
        q_data.push_back(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write on the port must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            total++;
            if (q_addr.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected none at %0t",
                         wr_addr, wr_data, $time);
            end else begin
                logic [4:0]  ea;
                logic [31:0] ed;
                ea = q_addr.pop_front();
                ed = q_data.pop_front();
                if (wr_addr !== ea || wr_data !== ed) begin
                    bad++;
                    $display("FAIL write_order: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h at %0t",
                             wr_addr, wr_data, ea, ed, $time);
                end else begin
                    $display("write addr=%0d data=0x%0h ok at %0t", wr_addr, wr_data, $time);
                end
            end
            shadow[wr_addr] = wr_data;
        end
    end

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
        pend_addr_a = '0; pend_addr_b = '0;
        for (int i = 0; i < 32; i++) shadow[i] = '0;

        // Reset state
        #2;
        chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("rst_wr_addr", {27'b0, wr_addr}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_rst_ld_ready", {31'b0, ld_ready}, 32'd1);

        // ALU only
        tick();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        expect_wr(5'd5, 32'h11);
        #1 chk("alu_only_stall", {31'b0, alu_stall}, 32'd0);
        tick();
        alu_valid = 1'b0;
        #1 chk("alu_only_stall_after", {31'b0, alu_stall}, 32'd0);

        // Load into idle block
        tick();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hAB; pend_addr_a = 5'd7;
        expect_wr(5'd7, 32'hAB);
        #1 chk("ld_idle_ready", {31'b0, ld_ready}, 32'd1);
        chk("ld_idle_hit_c0", {31'b0, pend_hit_a}, 32'd0);
        tick();
        ld_valid = 1'b0;
        #1 chk("ld_idle_hit_c1", {31'b0, pend_hit_a}, 32'd1);
        tick();
        chk("ld_idle_wr_en_e2", {31'b0, wr_en}, 32'd1);
        chk("ld_idle_wr_addr_e2", {27'b0, wr_addr}, 32'd7);
        chk("ld_idle_hit_after", {31'b0, pend_hit_a}, 32'd0);

        // Fill FIFO with loads 1..4 while ALU writes rd 9 every cycle
        for (int i = 0; i < 4; i++) begin
            tick();
            ld_valid = 1'b1; ld_rd = 5'(i + 1); ld_data = 32'hD0 + 32'(i);
            alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h90 + 32'(i);
            expect_wr(5'd9, 32'h90 + 32'(i));
            #1 chk("fill_ld_ready", {31'b0, ld_ready}, 32'd1);
            chk("fill_alu_stall", {31'b0, alu_stall}, 32'd0);
        end
        tick();
        ld_valid = 1'b0; alu_data = 32'h94; pend_addr_a = 5'd4; pend_addr_b = 5'd9;
        expect_wr(5'd1, 32'hD0);
        #1 chk("full_ld_ready", {31'b0, ld_ready}, 32'd0);
        chk("full_alu_stall", {31'b0, alu_stall}, 32'd1);
        chk("full_hit_4", {31'b0, pend_hit_a}, 32'd1);
        chk("full_hit_9", {31'b0, pend_hit_b}, 32'd0);
        tick();
        expect_wr(5'd9, 32'h94);
        #1 chk("after_pop_alu_stall", {31'b0, alu_stall}, 32'd0);
        chk("after_pop_ld_ready", {31'b0, ld_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        expect_wr(5'd2, 32'hD1);
        expect_wr(5'd3, 32'hD2);
        expect_wr(5'd4, 32'hD3);
        repeat (4) tick();

        // WAW between a buffered load and a later ALU write to the same register
        tick();
        ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h66; pend_addr_a = 5'd6;
        expect_wr(5'd6, 32'h66);
        tick();
        ld_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h77;
        #1 chk("waw_stall", {31'b0, alu_stall}, 32'd1);
        chk("waw_hit_6", {31'b0, pend_hit_a}, 32'd1);
        tick();
        expect_wr(5'd6, 32'h77);
        #1 chk("waw_stall_clear", {31'b0, alu_stall}, 32'd0);
        tick();
        alu_valid = 1'b0;
        repeat (2) tick();
        chk("waw_final_reg6", shadow[6], 32'h77);

        // Register 0 is never written
        tick();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h44; pend_addr_a = 5'd0;
        #1 chk("zero_alu_stall", {31'b0, alu_stall}, 32'd0);
        chk("zero_ld_ready", {31'b0, ld_ready}, 32'd1);
        chk("zero_hit", {31'b0, pend_hit_a}, 32'd0);
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        #1 chk("zero_wr_en", {31'b0, wr_en}, 32'd0);
        repeat (3) tick();

        // Reset while three loads are buffered behind ALU traffic
        for (int i = 0; i < 3; i++) begin
            tick();
            ld_valid = 1'b1; ld_rd = 5'(10 + i); ld_data = 32'hE0 + 32'(i);
            alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0 + 32'(i);
            expect_wr(5'd20, 32'hA0 + 32'(i));
        end
        tick();
        ld_valid = 1'b0; alu_valid = 1'b0; pend_addr_a = 5'd10; pend_addr_b = 5'd12;
        #1 chk("pre_rst_hit_10", {31'b0, pend_hit_a}, 32'd1);
        chk("pre_rst_hit_12", {31'b0, pend_hit_b}, 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("mid_rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("mid_rst_wr_addr", {27'b0, wr_addr}, 32'd0);
        chk("mid_rst_wr_data", wr_data, 32'd0);
        chk("mid_rst_ld_ready", {31'b0, ld_ready}, 32'd0);
        chk("mid_rst_hit_a", {31'b0, pend_hit_a}, 32'd0);
        chk("mid_rst_hit_b", {31'b0, pend_hit_b}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_mid_rst_ld_ready", {31'b0, ld_ready}, 32'd1);
        chk("post_mid_rst_hit", {31'b0, pend_hit_a}, 32'd0);
        repeat (6) tick();

        // Every expected write must have been observed
        for (int i = 0; i < 20 && q_addr.size() != 0; i++) tick();
        chk("queue_drained", 32'(q_addr.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
